// File: rtl/down_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer_pkg
//  Description : Shared types and helpers for the down_timer block.
//                - dt_state_t : timer FSM state encoding (2 bits)
//                - presc_width: width of the prescaler counter
//  Revision    : 1.0 - initial release
// ============================================================================
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dt_state_t;

    // Bits needed to count 0..div-1; never less than one bit so the
    // prescaler register stays legal when div == 1.
    function automatic int presc_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : down_timer_pkg
`default_nettype wire

// File: rtl/down_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer_if
//  Description : Control/status bundle of the down_timer.
//                master : drives en, load, load_val, start, abort;
//                         observes count, busy, done, zero
//                slave  : the timer side (directions reversed)
//  Revision    : 1.0 - initial release
// ============================================================================
interface down_timer_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output en, load, load_val, start, abort,
        input  count, busy, done, zero
    );

    modport slave (
        input  en, load, load_val, start, abort,
        output count, busy, done, zero
    );
endinterface : down_timer_if
`default_nettype wire

// File: rtl/down_timer_presc.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer_presc
//  Description : Tick prescaler. Counts enabled cycles 0..PRESC_DIV-1 and
//                emits tick on the enabled cycle at PRESC_DIV-1.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                clr  - synchronous clear (counter back to 0, no tick)
//                en   - count enable
//                tick - one-cycle decrement strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module down_timer_presc
    import down_timer_pkg::*;
#(
    parameter int PRESC_DIV = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      tick
);
    localparam int              c_W    = presc_width(PRESC_DIV);
    localparam logic [c_W-1:0]  c_LAST = c_W'(PRESC_DIV - 1);

    logic [c_W-1:0] r_cnt;
    logic           w_last;

    // With PRESC_DIV == 1 the counter is pinned at 0 and w_last is always
    // true, so tick reduces to en.
    assign w_last = (r_cnt == c_LAST);
    assign tick   = en & w_last & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_W'(1);
        end
    end
endmodule : down_timer_presc
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer
//  Description : Loadable down-counting timer. Loads a start value,
//                decrements on (prescaled) enabled ticks while running and
//                pulses done for one cycle on reaching zero.
//  Ports       : clk - clock, rising edge
//                rst - asynchronous active-high reset
//                bus - down_timer_if.slave
//                      in : en, load, load_val, start, abort
//                      out: count, busy, done (state decode), zero (comb.)
//  Config      : DOWN_TIMER_AUTO_RELOAD_EN - when defined, DONE reloads the
//                last loaded value and re-enters RUN (periodic mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRESC_DIV = 1
) (
    input wire logic    clk,
    input wire logic    rst,
    down_timer_if.slave bus
);
    dt_state_t        r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_start_cnt;
    logic             w_tick;
    logic             w_presc_clr;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // The reload register only exists in the build that reads it back.
    logic [WIDTH-1:0] r_reload;
`endif

    // Count value a same-cycle start would see in IDLE (load applied first).
    assign w_start_cnt = bus.load ? bus.load_val : r_count;

    // Prescaler restarts on every load and outside RUN; the IDLE/DONE
    // clear also covers start, which is only honoured in IDLE.
    assign w_presc_clr = (r_state != RUN) | bus.load;

    down_timer_presc #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_presc_clr),
        .en   (bus.en),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_count  <= bus.load_val;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        r_reload <= bus.load_val;
`endif
                    end
                    if (bus.start && (w_start_cnt != '0)) begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (bus.load) begin
                        r_count  <= bus.load_val;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        r_reload <= bus.load_val;
`endif
                        if (bus.load_val == '0) begin
                            r_state <= DONE;
                        end
                    end else if (w_tick) begin
                        r_count <= r_count - WIDTH'(1);
                        if (r_count == WIDTH'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end

                DONE: begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    if (bus.abort || (r_reload == '0)) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else begin
                        r_state <= RUN;
                        r_count <= r_reload;
                    end
`else
                    r_state <= IDLE;
                    r_count <= '0;
`endif
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = (r_state == RUN);
    assign bus.done  = (r_state == DONE);
    assign bus.zero  = (r_count == '0);
endmodule : down_timer
`default_nettype wire
